// File: rtl/fifo_rd_packer.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_rd_packer
//  Purpose  : Read-side consumer for the 8-entry async FIFO. Pops bytes from
//             the FIFO, whose read data arrives one cycle after fifo_r_en.
//             Packs them little-endian into BPW-byte words and presents each
//             word on a valid/ready stream. A flush pulse emits any partial
//             word, with the unused upper bytes forced to zero.
//  Ports    : clk          - read-side clock (FIFO clk_r)
//             nrst         - synchronous active-low reset
//             fifo_empty   - FIFO empty flag
//             fifo_r_data  - FIFO registered read data
//             fifo_r_en    - FIFO read enable (combinational)
//             flush        - single-cycle pulse, emit any partial word
//             out_valid    - output word valid
//             out_ready    - downstream accept
//             out_data     - packed word, byte k at [DW*k +: DW]
//             out_bytes    - number of valid bytes in out_data (1..BPW)
//             busy         - work in flight, accumulated or waiting
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_packer #(
   parameter int DW  = 8,
   parameter int BPW = 4,
   parameter int CW  = 3
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              fifo_empty,
   input  logic [DW-1:0]     fifo_r_data,
   output logic              fifo_r_en,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DW*BPW-1:0] out_data,
   output logic [CW-1:0]     out_bytes,
   output logic              busy
);

   localparam logic [CW-1:0] LAST_IDX  = CW'(BPW - 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(BPW);
   localparam logic [CW:0]   ROOM_LIM  = (CW+1)'(BPW - 1);

   logic              pend;
   logic [CW-1:0]     acc_cnt;
   logic              flush_pend;
   logic [DW*BPW-1:0] acc_data;

   logic [CW:0]       inflight;
   logic              xfer;
   logic              full_load;
   logic              flush_fire;
   logic              flush_load;
   logic [DW*BPW-1:0] full_word;
   logic [DW*BPW-1:0] flush_word;

   // Bytes already held plus the one arriving next cycle.
   assign inflight = {1'b0, acc_cnt} + {{CW{1'b0}}, pend};

   // While fewer than BPW-1 bytes are committed, reading cannot complete a
   // word, so it is safe even with a stalled output register. Otherwise the
   // output register must be free (or freeing) by the time the word lands.
   assign fifo_r_en = nrst && !fifo_empty && !flush_pend && !flush &&
                      ((inflight < ROOM_LIM) || !out_valid || out_ready);

   assign xfer       = out_valid && out_ready;
   assign full_load  = pend && (acc_cnt == LAST_IDX);
   // A flush completes only after the in-flight byte has been captured and
   // the output register can accept a word.
   assign flush_fire = flush_pend && !pend && (!out_valid || xfer);
   assign flush_load = flush_fire && (acc_cnt != '0);

   // The last byte of a full word comes straight from the FIFO.
   assign full_word = {fifo_r_data, acc_data[DW*(BPW-1)-1:0]};

   // Partial word: stale bytes above acc_cnt are zeroed.
   for (genvar k = 0; k < BPW; k++) begin : g_flush_byte
      assign flush_word[DW*k +: DW] = (CW'(k) < acc_cnt) ? acc_data[DW*k +: DW]
                                                         : {DW{1'b0}};
   end

   assign busy = pend || (acc_cnt != '0) || flush_pend || out_valid;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         pend       <= 1'b0;
         acc_cnt    <= '0;
         flush_pend <= 1'b0;
         acc_data   <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_bytes  <= '0;
      end else begin
         pend <= fifo_r_en;

         // Capture the fresh byte into its slot.
         for (int k = 0; k < BPW; k++) begin
            if (pend && (acc_cnt == CW'(k))) begin
               acc_data[DW*k +: DW] <= fifo_r_data;
            end
         end

         if (pend) begin
            acc_cnt <= (acc_cnt == LAST_IDX) ? '0 : acc_cnt + CW'(1);
         end else if (flush_load) begin
            acc_cnt <= '0;
         end

         // A flush seen while one is already pending is absorbed.
         if (flush_fire) begin
            flush_pend <= 1'b0;
         end else if (flush) begin
            flush_pend <= 1'b1;
         end

         // full_load needs pend=1 and flush_fire needs pend=0, so at most
         // one kind of word loads on any edge.
         if (full_load) begin
            out_data  <= full_word;
            out_bytes <= FULL_CNT;
            out_valid <= 1'b1;
         end else if (flush_load) begin
            out_data  <= flush_word;
            out_bytes <= acc_cnt;
            out_valid <= 1'b1;
         end else if (xfer) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_rd_packer
//  Purpose  : Self-checking bench for fifo_rd_packer. Models the FIFO with a
//             byte array and 1-cycle read latency. Predicts output words from
//             the sequence of popped bytes and flush pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_packer;

   localparam int DW  = 8;
   localparam int BPW = 4;
   localparam int CW  = 3;

   typedef struct packed {
      logic [DW*BPW-1:0] d;
      logic [CW-1:0]     n;
   } word_t;

   logic              clk = 1'b0;
   logic              nrst = 1'b0;
   logic              flush = 1'b0;
   logic              out_ready = 1'b0;
   logic              fifo_empty;
   logic              fifo_r_en;
   logic [DW-1:0]     fifo_r_data = '0;
   logic              out_valid;
   logic [DW*BPW-1:0] out_data;
   logic [CW-1:0]     out_bytes;
   logic              busy;

   // FIFO model: byte store with write and read pointers.
   logic [DW-1:0] fifo_mem [256];
   int            wr_total = 0;
   int            rd_total = 0;
   assign fifo_empty = (wr_total == rd_total);

   // Reference model state.
   logic [DW-1:0] part [$];
   word_t         exp_q [$];

   int n_vec = 0;
   int n_err = 0;
   int ren_cnt = 0;
   int stall_cnt = 0;
   int words_seen = 0;

   logic              ren_s = 1'b0;
   logic              prev_nrst = 1'b1;
   logic              hold_prev = 1'b0;
   logic [DW*BPW-1:0] prev_data = '0;
   logic [CW-1:0]     prev_bytes = '0;
   logic [DW*BPW-1:0] last_data = '0;
   logic [CW-1:0]     last_bytes = '0;

   fifo_rd_packer #(.DW(DW), .BPW(BPW), .CW(CW)) dut (
      .clk         (clk),
      .nrst        (nrst),
      .fifo_empty  (fifo_empty),
      .fifo_r_data (fifo_r_data),
      .fifo_r_en   (fifo_r_en),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_bytes   (out_bytes),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic emit_word();
      word_t w;
      w.d = '0;
      for (int i = 0; i < part.size(); i++) w.d[DW*i +: DW] = part[i];
      w.n = CW'(part.size());
      exp_q.push_back(w);
      part.delete();
   endtask

   task automatic push(input logic [DW-1:0] b);
      fifo_mem[wr_total & 255] = b;
      wr_total = wr_total + 1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // FIFO read port: registered data, popped on the cycle r_en was high.
   always @(posedge clk) begin
      if (!nrst) begin
         rd_total    <= wr_total;
         fifo_r_data <= '0;
      end else if (ren_s) begin
         fifo_r_data <= fifo_mem[rd_total & 255];
         rd_total    <= rd_total + 1;
      end
   end

   // Mid-cycle monitor: reference model and output checks.
   always @(negedge clk) begin
      word_t w;
      ren_s = fifo_r_en;
      if (!prev_nrst) begin
         check_val("rst_out_valid", out_valid, 0);
         check_val("rst_out_data", out_data, 0);
         check_val("rst_out_bytes", out_bytes, 0);
         check_val("rst_busy", busy, 0);
      end
      if (!nrst) begin
         part.delete();
         exp_q.delete();
      end else begin
         if (fifo_empty) check_val("ren_while_empty", fifo_r_en, 0);
         else if (!fifo_r_en) stall_cnt++;
         if (hold_prev) begin
            check_val("hold_valid", out_valid, 1);
            check_val("hold_data", out_data, prev_data);
            check_val("hold_bytes", out_bytes, prev_bytes);
         end
         if (out_valid && out_ready) begin
            words_seen++;
            last_data  = out_data;
            last_bytes = out_bytes;
            if (exp_q.size() == 0) begin
               check_val("expected_words_left", 64'(exp_q.size()), 1);
            end else begin
               w = exp_q.pop_front();
               check_val("word_data", out_data, w.d);
               check_val("word_bytes", out_bytes, w.n);
            end
         end
         if (fifo_r_en) begin
            part.push_back(fifo_mem[rd_total & 255]);
            ren_cnt++;
            if (part.size() == BPW) emit_word();
         end
         if (flush && part.size() != 0) emit_word();
      end
      hold_prev  = nrst && out_valid && !out_ready;
      prev_data  = out_data;
      prev_bytes = out_bytes;
      prev_nrst  = nrst;
   end

   initial begin
      int r0, s0, w0, pushed;

      nrst = 1'b0;
      repeat (3) @(posedge clk);
      #1 nrst = 1'b1;

      // Single word.
      out_ready = 1'b1;
      r0 = ren_cnt;
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      repeat (10) step();
      check_val("t1_reads", 64'(ren_cnt - r0), 4);
      check_val("t1_empty", fifo_empty, 1);
      check_val("t1_word", last_data, 32'h44332211);
      check_val("t1_bytes", last_bytes, 4);

      // Streaming at full rate.
      s0 = stall_cnt;
      w0 = words_seen;
      pushed = 0;
      for (int c = 0; c < 200 && pushed < 16; c++) begin
         if (wr_total - rd_total < 8) begin
            push(DW'(pushed));
            pushed++;
         end
         step();
      end
      repeat (10) step();
      check_val("t2_stalls", 64'(stall_cnt - s0), 0);
      check_val("t2_words", 64'(words_seen - w0), 4);
      check_val("t2_last_word", last_data, 32'h0F0E0D0C);

      // Backpressure.
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) push(DW'(i));
      repeat (12) step();
      check_val("t3_valid", out_valid, 1);
      check_val("t3_held_word", out_data, 32'h03020100);
      check_val("t3_fifo_left", 64'(wr_total - rd_total), 1);
      check_val("t3_ren_stopped", fifo_r_en, 0);
      out_ready = 1'b1;
      repeat (12) step();
      check_val("t3_second_word", last_data, 32'h07060504);
      check_val("t3_empty", fifo_empty, 1);

      // Partial flush one cycle after the second read.
      push(8'hAA); push(8'hBB);
      step();
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      for (int c = 0; c < 20 && !out_valid; c++) step();
      check_val("t4_valid", out_valid, 1);
      check_val("t4_word", out_data, 32'h0000BBAA);
      check_val("t4_bytes", out_bytes, 2);
      repeat (4) step();
      check_val("t4_idle", busy, 0);

      // Flush with nothing pending.
      w0 = words_seen;
      flush = 1'b1;
      step();
      flush = 1'b0;
      check_val("t6_pending", busy, 1);
      check_val("t6_no_valid", out_valid, 0);
      step();
      check_val("t6_cleared", busy, 0);
      repeat (3) step();
      check_val("t6_no_word", 64'(words_seen - w0), 0);

      // Reset with acc_cnt=2 and a byte in flight.
      push(8'hC1); push(8'hC2); push(8'hC3);
      step();
      step();
      step();
      check_val("t5_busy_before", busy, 1);
      nrst = 1'b0;
      step();
      check_val("t5_valid", out_valid, 0);
      check_val("t5_data", out_data, 0);
      check_val("t5_busy", busy, 0);
      check_val("t5_ren", fifo_r_en, 0);
      nrst = 1'b1;
      push(8'hDE); push(8'hAD); push(8'hBE); push(8'hEF);
      repeat (10) step();
      check_val("t5_clean_word", last_data, 32'hEFBEADDE);
      check_val("t5_clean_bytes", last_bytes, 4);

      // Randomised traffic.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 49) == 0);
         nrst      = ($urandom_range(0, 799) != 0);
         if (nrst && (wr_total - rd_total < 8) && ($urandom_range(0, 2) != 0))
            push(DW'($urandom_range(0, 255)));
         step();
      end

      // Drain.
      nrst = 1'b1;
      flush = 1'b0;
      out_ready = 1'b1;
      repeat (20) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      for (int c = 0; c < 50 && busy; c++) step();
      check_val("drain_busy", busy, 0);
      check_val("drain_words_left", 64'(exp_q.size()), 0);
      check_val("drain_fifo_empty", fifo_empty, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
